z80_rom_ctrl: RTL and testbench

Z80_ROM_CTRL -- requirements
Module: z80_rom_ctrl

---
 rtl/z80_rom_ctrl.sv | 78 +++++++
 tb/tb_z80_rom_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_rom_ctrl.sv
// z80_rom_ctrl: banked ROM window for a Z80 bus, fetching bytes over a req/ack memory handshake
module z80_rom_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] SDA,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  output logic        nWAIT,
  output logic [7:0]  ROM_DOUT,
  output logic        ROM_SEL,
  output logic        MEM_REQ,
  output logic [21:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_DATA,
  output logic [31:0] BANK
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, next_state;
  logic [7:0] bank [4];
  logic [21:0] rom_addr;
  logic rom_rd, io_ld, start, ack, unused_wr;
  assign unused_wr = nWR;
  assign rom_rd = ~nMREQ & ~nRD & (SDA < 16'hF800);
  assign io_ld = ~nIORQ & ~nRD & (SDA[7:2] == 6'b000010);
  assign start = (state == IDLE) & rom_rd;
  assign ack = (state == REQ) & MEM_ACK;
  assign nWAIT = ~(rom_rd & (state != DONE));
  assign ROM_SEL = rom_rd;
  assign BANK = {bank[3], bank[2], bank[1], bank[0]};
  // Window decode: each region above 8000h maps its low bits under one bank register
  always_comb begin
    rom_addr = !SDA[15] ? {7'd0, SDA[14:0]} :
               !SDA[14] ? {bank[3], SDA[13:0]} :
               !SDA[13] ? {1'b0, bank[2], SDA[12:0]} :
               !SDA[12] ? {2'b0, bank[1], SDA[11:0]} :
                          {3'b0, bank[0], SDA[10:0]};
  end
  // Bank registers load from I/O reads of ports 08h-0Bh; reset gives a linear map
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bank[0] <= 8'h1E;
      bank[1] <= 8'h0E;
      bank[2] <= 8'h06;
      bank[3] <= 8'h02;
    end else if (io_ld) begin
      bank[SDA[1:0]] <= SDA[15:8];
    end
  end
  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else state <= next_state;
  end
  // DONE holds until the strobes release so a stretched cycle fetches only once
  always_comb begin
    next_state = state;
    next_state = start ? REQ : ack ? DONE : (state == DONE && !rom_rd) ? IDLE : state;
  end
  // Request issue and data capture; an aborted read still completes its fetch
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MEM_REQ <= 1'b0;
      MEM_ADDR <= '0;
      ROM_DOUT <= '0;
    end else begin
      if (start) begin
        MEM_REQ <= 1'b1;
        MEM_ADDR <= rom_addr;
      end
      if (ack) begin
        MEM_REQ <= 1'b0;
        ROM_DOUT <= MEM_DATA;
      end
    end
  end
endmodule

// File: tb/tb_z80_rom_ctrl.sv
// tb_z80_rom_ctrl: randomized and directed checks of z80_rom_ctrl against a bank/address model
module tb_z80_rom_ctrl;
  logic CLK = 0, RESET = 1;
  logic [15:0] SDA = '0;
  logic nMREQ = 1, nIORQ = 1, nRD = 1, nWR = 1, MEM_ACK = 0;
  logic [7:0] MEM_DATA = '0;
  logic nWAIT, ROM_SEL, MEM_REQ;
  logic [7:0] ROM_DOUT;
  logic [21:0] MEM_ADDR;
  logic [31:0] BANK;
  int total = 0, bad = 0, req_pulses = 0;
  logic req_q = 0;
  logic [7:0] mb [4];

  z80_rom_ctrl dut (
    .CLK(CLK), .RESET(RESET), .SDA(SDA), .nMREQ(nMREQ), .nIORQ(nIORQ),
    .nRD(nRD), .nWR(nWR), .nWAIT(nWAIT), .ROM_DOUT(ROM_DOUT), .ROM_SEL(ROM_SEL),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
    .BANK(BANK)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (MEM_REQ === 1'b1 && req_q !== 1'b1) req_pulses++;
    req_q = MEM_REQ;
  end

  function automatic void model_reset();
    mb[0] = 8'h1E; mb[1] = 8'h0E; mb[2] = 8'h06; mb[3] = 8'h02;
  endfunction

  function automatic logic [31:0] exp_bank();
    return {mb[3], mb[2], mb[1], mb[0]};
  endfunction

  function automatic logic [21:0] exp_addr(input logic [15:0] a);
    int r;
    if (a < 16'h8000) r = int'(a);
    else if (a < 16'hC000) r = int'(mb[3]) * 'h4000 + (int'(a) - 'h8000);
    else if (a < 16'hE000) r = int'(mb[2]) * 'h2000 + (int'(a) - 'hC000);
    else if (a < 16'hF000) r = int'(mb[1]) * 'h1000 + (int'(a) - 'hE000);
    else r = int'(mb[0]) * 'h800 + (int'(a) - 'hF000);
    return r[21:0];
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_bus();
    nMREQ = 1; nIORQ = 1; nRD = 1; nWR = 1; MEM_ACK = 0;
  endtask

  task automatic rom_read(input logic [15:0] a, input int d, input logic [7:0] dat, input bit also_io);
    int w, p0;
    logic [21:0] ea;
    bit stable;
    ea = exp_addr(a); p0 = req_pulses; stable = 1;
    SDA = a; nMREQ = 0; nRD = 0; MEM_ACK = 0;
    if (also_io) nIORQ = 0;
    #1;
    w = (nWAIT === 1'b0) ? 1 : 0;
    total++;
    if (ROM_SEL !== 1'b1 || MEM_REQ !== 1'b0) begin
      bad++; $display("FAIL rd_start %h: sel=%b req=%b want sel=1 req=0", a, ROM_SEL, MEM_REQ);
    end
    step();
    if (nWAIT === 1'b0) w++;
    total++;
    if (MEM_REQ !== 1'b1 || MEM_ADDR !== ea) begin
      bad++; $display("FAIL rd_addr %h: req=%b addr=%h want req=1 addr=%h", a, MEM_REQ, MEM_ADDR, ea);
    end
    repeat (d) begin
      step();
      if (nWAIT === 1'b0) w++;
      if (MEM_REQ !== 1'b1 || MEM_ADDR !== ea) stable = 0;
    end
    total++;
    if (!stable) begin
      bad++; $display("FAIL rd_hold %h: req=%b addr=%h want req=1 addr=%h", a, MEM_REQ, MEM_ADDR, ea);
    end
    MEM_ACK = 1; MEM_DATA = dat;
    step();
    MEM_ACK = 0; MEM_DATA = ~dat;
    #1;
    total++;
    if (ROM_DOUT !== dat || MEM_REQ !== 1'b0 || nWAIT !== 1'b1) begin
      bad++; $display("FAIL rd_done %h: dout=%h req=%b wait=%b want dout=%h req=0 wait=1", a, ROM_DOUT, MEM_REQ, nWAIT, dat);
    end
    total++;
    if (w != d + 2) begin
      bad++; $display("FAIL rd_wait_len %h: got %0d want %0d", a, w, d + 2);
    end
    step();
    total++;
    if (MEM_REQ !== 1'b0 || nWAIT !== 1'b1 || ROM_DOUT !== dat) begin
      bad++; $display("FAIL rd_held_done %h: req=%b wait=%b dout=%h want 0 1 %h", a, MEM_REQ, nWAIT, ROM_DOUT, dat);
    end
    if (also_io && a[7:2] == 6'b000010) mb[a[1:0]] = a[15:8];
    idle_bus();
    step();
    total++;
    if (req_pulses != p0 + 1 || BANK !== exp_bank()) begin
      bad++; $display("FAIL rd_pulses %h: pulses=%0d bank=%h want pulses=%0d bank=%h", a, req_pulses - p0, BANK, 1, exp_bank());
    end
  endtask

  task automatic rom_abort(input logic [15:0] a, input int d, input logic [7:0] dat);
    logic [21:0] ea;
    bit stable;
    ea = exp_addr(a); stable = 1;
    SDA = a; nMREQ = 0; nRD = 0; MEM_ACK = 0;
    step();
    total++;
    if (MEM_REQ !== 1'b1 || MEM_ADDR !== ea) begin
      bad++; $display("FAIL ab_addr %h: req=%b addr=%h want 1 %h", a, MEM_REQ, MEM_ADDR, ea);
    end
    idle_bus();
    #1;
    total++;
    if (nWAIT !== 1'b1 || ROM_SEL !== 1'b0 || MEM_REQ !== 1'b1) begin
      bad++; $display("FAIL ab_drop %h: wait=%b sel=%b req=%b want 1 0 1", a, nWAIT, ROM_SEL, MEM_REQ);
    end
    repeat (d) begin
      step();
      if (MEM_REQ !== 1'b1 || MEM_ADDR !== ea) stable = 0;
    end
    total++;
    if (!stable) begin
      bad++; $display("FAIL ab_hold %h: req=%b addr=%h want 1 %h", a, MEM_REQ, MEM_ADDR, ea);
    end
    MEM_ACK = 1; MEM_DATA = dat;
    step();
    MEM_ACK = 0;
    total++;
    if (ROM_DOUT !== dat || MEM_REQ !== 1'b0) begin
      bad++; $display("FAIL ab_done %h: dout=%h req=%b want %h 0", a, ROM_DOUT, MEM_REQ, dat);
    end
    step();
  endtask

  task automatic io_cycle(input logic [7:0] port, input logic [7:0] hi, input int mode);
    SDA = {hi, port}; nIORQ = 0;
    if (mode == 0) nRD = 0;
    if (mode == 1) nWR = 0;
    #1;
    total++;
    if (nWAIT !== 1'b1 || MEM_REQ !== 1'b0) begin
      bad++; $display("FAIL io_quiet %h: wait=%b req=%b want 1 0", SDA, nWAIT, MEM_REQ);
    end
    step();
    idle_bus();
    if (mode == 0 && port >= 8'h08 && port <= 8'h0B) mb[port[1:0]] = hi;
    #1;
    total++;
    if (BANK !== exp_bank()) begin
      bad++; $display("FAIL io_bank port=%h mode=%0d: got %h want %h", port, mode, BANK, exp_bank());
    end
  endtask

  task automatic test_reset();
    RESET = 1; idle_bus();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if (MEM_REQ !== 1'b0 || MEM_ADDR !== 22'h0 || ROM_DOUT !== 8'h00 || nWAIT !== 1'b1 || ROM_SEL !== 1'b0) begin
      bad++; $display("FAIL reset_out: req=%b addr=%h dout=%h wait=%b sel=%b want 0 0 00 1 0", MEM_REQ, MEM_ADDR, ROM_DOUT, nWAIT, ROM_SEL);
    end
    total++;
    if (BANK !== 32'h02060E1E) begin
      bad++; $display("FAIL reset_bank: got %h want 02060e1e", BANK);
    end
    RESET = 0;
    step();
  endtask

  task automatic test_basic();
    rom_read(16'h1234, 3, 8'h5A, 0);
    total++;
    if (MEM_ADDR !== 22'h001234) begin
      bad++; $display("FAIL basic_addr: got %h want 001234", MEM_ADDR);
    end
  endtask

  task automatic test_default_top();
    rom_read(16'hF7FF, 1, 8'hC3, 0);
    total++;
    if (MEM_ADDR !== 22'h00F7FF) begin
      bad++; $display("FAIL top_addr: got %h want 00f7ff", MEM_ADDR);
    end
  endtask

  task automatic test_bank_load();
    io_cycle(8'h0B, 8'h25, 0);
    rom_read(16'h8001, 0, 8'h11, 0);
    total++;
    if (MEM_ADDR !== 22'h094001) begin
      bad++; $display("FAIL bank_addr: got %h want 094001", MEM_ADDR);
    end
    io_cycle(8'h09, 8'h77, 1);
    io_cycle(8'h0A, 8'h66, 2);
    io_cycle(8'h0C, 8'h55, 0);
    io_cycle(8'h07, 8'h44, 0);
    io_cycle(8'h08, 8'hFF, 0);
    rom_read(16'hF012, 2, 8'h22, 0);
  endtask

  task automatic test_nonrom();
    logic [7:0] keep;
    bit ok;
    keep = ROM_DOUT; ok = 1;
    SDA = 16'hF900; nMREQ = 0; nRD = 0;
    repeat (4) begin
      step();
      if (MEM_REQ !== 1'b0 || nWAIT !== 1'b1 || ROM_SEL !== 1'b0) ok = 0;
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL nonrom_f900: req=%b wait=%b sel=%b want 0 1 0", MEM_REQ, nWAIT, ROM_SEL);
    end
    idle_bus(); ok = 1;
    SDA = 16'h1000; nMREQ = 0; nWR = 0;
    repeat (4) begin
      step();
      if (MEM_REQ !== 1'b0 || nWAIT !== 1'b1 || ROM_SEL !== 1'b0) ok = 0;
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL nonrom_write: req=%b wait=%b sel=%b want 0 1 0", MEM_REQ, nWAIT, ROM_SEL);
    end
    idle_bus();
    MEM_ACK = 1; MEM_DATA = ~keep;
    step();
    MEM_ACK = 0;
    step();
    total++;
    if (ROM_DOUT !== keep || MEM_REQ !== 1'b0) begin
      bad++; $display("FAIL idle_ack: dout=%h req=%b want %h 0", ROM_DOUT, MEM_REQ, keep);
    end
  endtask

  task automatic test_back_to_back();
    rom_read(16'h0100, 1, 8'hA1, 0);
    rom_read(16'h0101, 0, 8'hB2, 0);
  endtask

  task automatic test_abort();
    rom_abort(16'h4321, 2, 8'h3C);
    rom_read(16'h4322, 1, 8'h4D, 0);
  endtask

  task automatic test_same_cycle();
    rom_read(16'h8009, 1, 8'h99, 1);
    total++;
    if (BANK[15:8] !== 8'h80) begin
      bad++; $display("FAIL same_bank1: got %h want 80", BANK[15:8]);
    end
    rom_read(16'hE123, 0, 8'h98, 0);
  endtask

  task automatic test_reset_in_req();
    rom_read(16'h0042, 0, 8'h77, 0);
    SDA = 16'h2345; nMREQ = 0; nRD = 0;
    step();
    total++;
    if (MEM_REQ !== 1'b1) begin
      bad++; $display("FAIL rir_req: got %b want 1", MEM_REQ);
    end
    RESET = 1;
    #1;
    total++;
    if (MEM_REQ !== 1'b0 || ROM_DOUT !== 8'h00 || MEM_ADDR !== 22'h0) begin
      bad++; $display("FAIL rir_async: req=%b dout=%h addr=%h want 0 00 0", MEM_REQ, ROM_DOUT, MEM_ADDR);
    end
    idle_bus();
    model_reset();
    step();
    RESET = 0;
    MEM_ACK = 1; MEM_DATA = 8'hA5;
    step();
    MEM_ACK = 0;
    step();
    total++;
    if (MEM_REQ !== 1'b0 || ROM_DOUT !== 8'h00 || nWAIT !== 1'b1 || BANK !== exp_bank()) begin
      bad++; $display("FAIL rir_after: req=%b dout=%h wait=%b bank=%h want 0 00 1 %h", MEM_REQ, ROM_DOUT, nWAIT, BANK, exp_bank());
    end
    rom_read(16'h2345, 1, 8'h5E, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 5);
      if (op <= 1) rom_read(16'($urandom_range(0, 'hF7FF)), $urandom_range(0, 4), 8'($urandom), 0);
      else if (op == 2) rom_abort(16'($urandom_range(0, 'hF7FF)), $urandom_range(0, 3), 8'($urandom));
      else if (op == 3) io_cycle(8'($urandom_range(6, 13)), 8'($urandom), 0);
      else io_cycle(8'($urandom_range(6, 13)), 8'($urandom), $urandom_range(1, 2));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_default_top();
    test_bank_load();
    test_nonrom();
    test_back_to_back();
    test_abort();
    test_same_cycle();
    test_reset_in_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
